maf_exp_align_stage: RTL and testbench

Second pipeline stage of the multi-precision multiply-add datapath. It computes the anchor exponent and the addend alignment shift for one wide lane or two split lanes. Mantissa payload and sign/hidden-bit sideband pass through alongside the results. Compared with the fixed-timing stage register, it adds elastic valid/ready flow control with a 2-entry skid buffer, synchronous flush, parametrised widths and biases, and an explicit error flag for reserved modes.

---
 rtl/maf_exp_align_stage_pkg.sv | 34 +++
 rtl/maf_exp_align_stage_if.sv | 40 ++++
 rtl/maf_exp_align_stage_lane.sv | 46 ++++
 rtl/maf_exp_align_stage.sv | 155 +++++++++++++++
 tb/tb_maf_exp_align_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maf_exp_align_stage_pkg.sv
// Shared types and default constants for the multiply-add exponent-alignment stage.
`default_nettype none

package maf_pkg;

    typedef enum logic [1:0] {
        MODE_D    = 2'b00,
        MODE_H2   = 2'b01,
        MODE_S    = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int DEF_DATA_W = 576;
    localparam int DEF_SIDE_W = 6;
    localparam int DEF_EW     = 14;
    localparam int DEF_OW     = 12;
    localparam int DEF_BIAS_D = 1023;
    localparam int DEF_PA_D   = 55;
    localparam int DEF_BIAS_S = 127;
    localparam int DEF_PA_S   = 26;
    localparam int DEF_BIAS_H = 15;
    localparam int DEF_PA_H   = 13;

    // Result fields are sized by the package default output width.
    typedef struct packed {
        logic [DEF_OW-1:0] e;
        logic [DEF_OW-1:0] d;
        logic [1:0]        psel;
        logic              err;
    } res_t;

endpackage

`default_nettype wire

// File: rtl/maf_exp_align_stage_if.sv
// Upstream/downstream handshake bundle of the exponent-alignment stage.
`default_nettype none

interface maf_exp_align_stage_if #(
    parameter int DATA_W = 576,
    parameter int SIDE_W = 6,
    parameter int EW     = 14,
    parameter int OW     = 12
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [EW-1:0]     in_ea;
    logic [EW-1:0]     in_eb;
    logic [EW-1:0]     in_ec;
    logic [DATA_W-1:0] in_payload;
    logic [SIDE_W-1:0] in_side;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_e;
    logic [OW-1:0]     out_d;
    logic [1:0]        out_psel;
    logic [1:0]        out_mode;
    logic              out_err;
    logic [DATA_W-1:0] out_payload;
    logic [SIDE_W-1:0] out_side;

    modport master (
        output flush, in_valid, in_mode, in_ea, in_eb, in_ec, in_payload, in_side, out_ready,
        input  in_ready, out_valid, out_e, out_d, out_psel, out_mode, out_err, out_payload, out_side
    );

    modport slave (
        input  flush, in_valid, in_mode, in_ea, in_eb, in_ec, in_payload, in_side, out_ready,
        output in_ready, out_valid, out_e, out_d, out_psel, out_mode, out_err, out_payload, out_side
    );
endinterface

`default_nettype wire

// File: rtl/maf_exp_align_stage_lane.sv
// One exponent lane: anchor exponent, addend shift and product-anchors flag, all combinational.
`default_nettype none

module maf_exp_lane #(
    parameter int LW   = 14,
    parameter int OW_L = 12
) (
    input  logic [LW-1:0]   ea_i,
    input  logic [LW-1:0]   eb_i,
    input  logic [LW-1:0]   ec_i,
    input  logic [LW+2:0]   bias_i,
    input  logic [LW+2:0]   pa_i,
    output logic [OW_L-1:0] e_o,
    output logic [OW_L-1:0] d_o,
    output logic            psel_o
);
    localparam int SW = LW + 3;
    localparam logic signed [SW-1:0] C_MAX = SW'((2 ** OW_L) - 1);

    logic signed [SW-1:0] ep;
    logic signed [SW-1:0] ec_s;
    logic signed [SW-1:0] e_raw;
    logic signed [SW-1:0] d_raw;

    function automatic logic [OW_L-1:0] clamp(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (v > C_MAX)
            return '1;
        else
            return v[OW_L-1:0];
    endfunction

    assign ec_s   = $signed({3'b000, ec_i});
    assign ep     = $signed({3'b000, ea_i}) + $signed({3'b000, eb_i})
                  - $signed(bias_i) + $signed(pa_i);
    // Strict compare: a tie anchors on the addend.
    assign psel_o = (ep > ec_s);
    assign e_raw  = psel_o ? ep : ec_s;
    assign d_raw  = psel_o ? (ep - ec_s) : '0;
    assign e_o    = clamp(e_raw);
    assign d_o    = clamp(d_raw);

endmodule

`default_nettype wire

// File: rtl/maf_exp_align_stage.sv
// Exponent-alignment pipeline stage with a 2-entry skid buffer, flush and reserved-mode flag.
`default_nettype none

module maf_exp_align_stage
    import maf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SIDE_W = DEF_SIDE_W,
    parameter int EW     = DEF_EW,
    parameter int OW     = DEF_OW,
    parameter int BIAS_D = DEF_BIAS_D,
    parameter int PA_D   = DEF_PA_D,
    parameter int BIAS_S = DEF_BIAS_S,
    parameter int PA_S   = DEF_PA_S,
    parameter int BIAS_H = DEF_BIAS_H,
    parameter int PA_H   = DEF_PA_H
) (
    input  logic                 clk,
    input  logic                 rstn,
    maf_exp_align_stage_if.slave sif
);
    localparam int HEW = EW / 2;
    localparam int HOW = OW / 2;
    localparam int WSW = EW + 3;
    localparam int HSW = HEW + 3;

    typedef struct packed {
        res_t              res;
        logic [1:0]        mode;
        logic [DATA_W-1:0] payload;
        logic [SIDE_W-1:0] side;
    } entry_t;

    mode_e          mode;
    logic [WSW-1:0] wide_bias;
    logic [WSW-1:0] wide_pa;
    logic [OW-1:0]  wide_e;
    logic [OW-1:0]  wide_d;
    logic           wide_psel;
    logic [OW-1:0]  split_e;
    logic [OW-1:0]  split_d;
    logic [1:0]     split_psel;
    res_t           res;
    entry_t         new_entry;

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_vld_q, head_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   accept;
    logic   drain;

    assign mode      = mode_e'(sif.in_mode);
    assign wide_bias = (mode == MODE_S) ? WSW'(BIAS_S) : WSW'(BIAS_D);
    assign wide_pa   = (mode == MODE_S) ? WSW'(PA_S)   : WSW'(PA_D);

    maf_exp_lane #(.LW(EW), .OW_L(OW)) u_lane_wide (
        .ea_i   (sif.in_ea),
        .eb_i   (sif.in_eb),
        .ec_i   (sif.in_ec),
        .bias_i (wide_bias),
        .pa_i   (wide_pa),
        .e_o    (wide_e),
        .d_o    (wide_d),
        .psel_o (wide_psel)
    );

    for (genvar i = 0; i < 2; i++) begin : g_split
        maf_exp_lane #(.LW(HEW), .OW_L(HOW)) u_lane_half (
            .ea_i   (sif.in_ea[i*HEW +: HEW]),
            .eb_i   (sif.in_eb[i*HEW +: HEW]),
            .ec_i   (sif.in_ec[i*HEW +: HEW]),
            .bias_i (HSW'(BIAS_H)),
            .pa_i   (HSW'(PA_H)),
            .e_o    (split_e[i*HOW +: HOW]),
            .d_o    (split_d[i*HOW +: HOW]),
            .psel_o (split_psel[i])
        );
    end

    always_comb begin
        res = '0;
        unique case (mode)
            MODE_D, MODE_S: begin
                res.e    = wide_e;
                res.d    = wide_d;
                res.psel = {1'b0, wide_psel};
            end
            MODE_H2: begin
                res.e    = split_e;
                res.d    = split_d;
                res.psel = split_psel;
            end
            default: res.err = 1'b1;
        endcase
    end

    assign new_entry = '{res: res, mode: sif.in_mode, payload: sif.in_payload, side: sif.in_side};

    // Skid entry is the only overflow slot, so "skid empty" is exactly the ready condition.
    assign accept = sif.in_valid & ~skid_vld_q;
    assign drain  = head_vld_q & sif.out_ready;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        if (sif.flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!head_vld_q || drain) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                head_d     = new_entry;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = new_entry;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign sif.in_ready    = ~skid_vld_q;
    assign sif.out_valid   = head_vld_q;
    assign sif.out_e       = head_q.res.e;
    assign sif.out_d       = head_q.res.d;
    assign sif.out_psel    = head_q.res.psel;
    assign sif.out_err     = head_q.res.err;
    assign sif.out_mode    = head_q.mode;
    assign sif.out_payload = head_q.payload;
    assign sif.out_side    = head_q.side;

endmodule

`default_nettype wire

// File: tb/tb_maf_exp_align_stage.sv
// Bench for maf_exp_align_stage: directed cases plus randomized traffic against a queue model.
`default_nettype none

module tb_maf_exp_align_stage;
    localparam int DATA_W = 576;
    localparam int SIDE_W = 6;
    localparam int EW     = 14;
    localparam int OW     = 12;

    typedef struct {
        logic [OW-1:0]     e;
        logic [OW-1:0]     d;
        logic [1:0]        psel;
        logic              err;
        logic [1:0]        mode;
        logic [DATA_W-1:0] pay;
        logic [SIDE_W-1:0] side;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    maf_exp_align_stage_if #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .EW(EW), .OW(OW)) sif ();

    maf_exp_align_stage dut (
        .clk  (clk),
        .rstn (rstn),
        .sif  (sif)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   last_acc = 1'b0;

    function automatic void lane(input int a, input int b, input int c, input int bias,
                                 input int pa, input int w, output int e, output int d,
                                 output bit p);
        int ep;
        int mx;
        ep = a + b - bias + pa;
        mx = (1 << w) - 1;
        p  = ep > c;
        e  = p ? ep : c;
        d  = p ? ep - c : 0;
        if (e < 0) e = 0;
        if (e > mx) e = mx;
        if (d < 0) d = 0;
        if (d > mx) d = mx;
    endfunction

    function automatic exp_t ref_model(input logic [1:0] m, input logic [EW-1:0] a,
                                       input logic [EW-1:0] b, input logic [EW-1:0] c,
                                       input logic [DATA_W-1:0] pay, input logic [SIDE_W-1:0] side);
        exp_t r;
        int   e0, d0, e1, d1;
        bit   p0, p1;
        r.e = '0; r.d = '0; r.psel = '0; r.err = 1'b0;
        r.mode = m; r.pay = pay; r.side = side;
        case (m)
            2'd0, 2'd2: begin
                lane(int'(a), int'(b), int'(c), (m == 2'd0) ? 1023 : 127,
                     (m == 2'd0) ? 55 : 26, OW, e0, d0, p0);
                r.e    = e0[OW-1:0];
                r.d    = d0[OW-1:0];
                r.psel = {1'b0, p0};
            end
            2'd1: begin
                lane(int'(a[6:0]), int'(b[6:0]), int'(c[6:0]), 15, 13, OW/2, e0, d0, p0);
                lane(int'(a[13:7]), int'(b[13:7]), int'(c[13:7]), 15, 13, OW/2, e1, d1, p1);
                r.e    = {e1[5:0], e0[5:0]};
                r.d    = {d1[5:0], d0[5:0]};
                r.psel = {p1, p0};
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rand_pay();
        logic [DATA_W-1:0] p;
        for (int k = 0; k < DATA_W / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic chk_pay(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp_v);
        n_checks++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic check_state();
        chk("in_ready", 64'(sif.in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(sif.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_e", 64'(sif.out_e), 64'(q[0].e));
            chk("out_d", 64'(sif.out_d), 64'(q[0].d));
            chk("out_psel", 64'(sif.out_psel), 64'(q[0].psel));
            chk("out_err", 64'(sif.out_err), 64'(q[0].err));
            chk("out_mode", 64'(sif.out_mode), 64'(q[0].mode));
            chk("out_side", 64'(sif.out_side), 64'(q[0].side));
            chk_pay("out_payload", sif.out_payload, q[0].pay);
        end
    endtask

    // Advance one clock: update the model from the pre-edge handshake, then check.
    task automatic cycle();
        bit acc;
        bit drn;
        @(posedge clk);
        acc = 1'b0;
        if (sif.flush) begin
            q.delete();
        end else begin
            acc = sif.in_valid && (q.size() < 2);
            drn = (q.size() > 0) && sif.out_ready;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_model(sif.in_mode, sif.in_ea, sif.in_eb, sif.in_ec,
                                           sif.in_payload, sif.in_side));
        end
        last_acc = acc;
        #1;
        check_state();
    endtask

    task automatic set_beat(input logic [1:0] m, input logic [EW-1:0] a, input logic [EW-1:0] b,
                            input logic [EW-1:0] c);
        sif.in_mode    = m;
        sif.in_ea      = a;
        sif.in_eb      = b;
        sif.in_ec      = c;
        sif.in_payload = rand_pay();
        sif.in_side    = SIDE_W'($urandom);
    endtask

    task automatic send_until_accepted();
        sif.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", 64'(0), 64'(1));
        sif.in_valid = 1'b0;
    endtask

    task automatic dir(input string tag, input logic [1:0] m, input logic [EW-1:0] a,
                       input logic [EW-1:0] b, input logic [EW-1:0] c, input logic [OW-1:0] ee,
                       input logic [OW-1:0] ed, input logic [1:0] ep, input logic eerr);
        logic [DATA_W-1:0] pay;
        logic [SIDE_W-1:0] side;
        sif.out_ready = 1'b1;
        set_beat(m, a, b, c);
        pay  = sif.in_payload;
        side = sif.in_side;
        sif.in_valid = 1'b1;
        cycle();
        sif.in_valid = 1'b0;
        chk({tag, ".valid"}, 64'(sif.out_valid), 64'(1));
        chk({tag, ".e"}, 64'(sif.out_e), 64'(ee));
        chk({tag, ".d"}, 64'(sif.out_d), 64'(ed));
        chk({tag, ".psel"}, 64'(sif.out_psel), 64'(ep));
        chk({tag, ".err"}, 64'(sif.out_err), 64'(eerr));
        chk({tag, ".side"}, 64'(sif.out_side), 64'(side));
        chk_pay({tag, ".payload"}, sif.out_payload, pay);
        cycle();
    endtask

    initial begin
        rstn           = 1'b0;
        sif.flush      = 1'b0;
        sif.in_valid   = 1'b0;
        sif.out_ready  = 1'b0;
        sif.in_mode    = '0;
        sif.in_ea      = '0;
        sif.in_eb      = '0;
        sif.in_ec      = '0;
        sif.in_payload = '0;
        sif.in_side    = '0;
        #1;
        chk("rst.out_valid", 64'(sif.out_valid), 64'(0));
        chk("rst.in_ready", 64'(sif.in_ready), 64'(1));
        chk("rst.out_e", 64'(sif.out_e), 64'(0));
        chk_pay("rst.payload", sif.out_payload, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        dir("wideD_prod", 2'd0, 14'd1023, 14'd1023, 14'd1023, 12'd1078, 12'd55, 2'b01, 1'b0);
        dir("wideD_add", 2'd0, 14'd1023, 14'd1023, 14'd1100, 12'd1100, 12'd0, 2'b00, 1'b0);
        dir("wideD_tie", 2'd0, 14'd1023, 14'd1023, 14'd1078, 12'd1078, 12'd0, 2'b00, 1'b0);
        dir("splitH", 2'd1, {7'd15, 7'd15}, {7'd15, 7'd15}, {7'd40, 7'd15},
            {6'd40, 6'd28}, {6'd0, 6'd13}, 2'b01, 1'b0);
        dir("wideD_zero", 2'd0, 14'd0, 14'd0, 14'd0, 12'd0, 12'd0, 2'b00, 1'b0);
        dir("splitH_sat", 2'd1, {7'd15, 7'd0}, {7'd15, 7'd0}, {7'd127, 7'd0},
            {6'd63, 6'd0}, 12'd0, 2'b00, 1'b0);
        dir("wideS_prod", 2'd2, 14'd127, 14'd127, 14'd127, 12'd153, 12'd26, 2'b01, 1'b0);
        dir("wideD_ovf", 2'd0, 14'd16383, 14'd16383, 14'd0, 12'd4095, 12'd4095, 2'b01, 1'b0);
        dir("rsvd", 2'd3, 14'd5000, 14'd6000, 14'd7, 12'd0, 12'd0, 2'b00, 1'b1);

        // Backpressure: three beats into a stalled output.
        sif.out_ready = 1'b0;
        set_beat(2'd0, 14'd1000, 14'd1010, 14'd900);
        sif.in_valid = 1'b1;
        cycle();
        chk("bp.ready_after1", 64'(sif.in_ready), 64'(1));
        set_beat(2'd1, 14'd3000, 14'd2000, 14'd100);
        cycle();
        chk("bp.ready_after2", 64'(sif.in_ready), 64'(0));
        set_beat(2'd2, 14'd130, 14'd140, 14'd120);
        cycle();
        cycle();
        chk("bp.ready_full", 64'(sif.in_ready), 64'(0));
        chk("bp.valid_full", 64'(sif.out_valid), 64'(1));
        sif.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("bp.beat3_timeout", 64'(0), 64'(1));
        sif.in_valid = 1'b0;
        repeat (4) cycle();

        // Flush with both entries occupied and a beat on offer.
        sif.out_ready = 1'b0;
        set_beat(2'd0, 14'd1100, 14'd1000, 14'd50);
        send_until_accepted();
        set_beat(2'd2, 14'd100, 14'd90, 14'd10);
        send_until_accepted();
        set_beat(2'd1, 14'd555, 14'd777, 14'd333);
        sif.in_valid = 1'b1;
        sif.flush    = 1'b1;
        cycle();
        sif.flush    = 1'b0;
        sif.in_valid = 1'b0;
        chk("flush.out_valid", 64'(sif.out_valid), 64'(0));
        chk("flush.in_ready", 64'(sif.in_ready), 64'(1));
        sif.out_ready = 1'b1;
        repeat (3) begin
            cycle();
            chk("flush.empty", 64'(sif.out_valid), 64'(0));
        end

        // Asynchronous reset with entries held.
        sif.out_ready = 1'b0;
        set_beat(2'd0, 14'd1500, 14'd1500, 14'd20);
        send_until_accepted();
        set_beat(2'd1, 14'd999, 14'd888, 14'd77);
        send_until_accepted();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst.out_valid", 64'(sif.out_valid), 64'(0));
        chk("arst.in_ready", 64'(sif.in_ready), 64'(1));
        chk("arst.out_e", 64'(sif.out_e), 64'(0));
        chk("arst.out_d", 64'(sif.out_d), 64'(0));
        chk("arst.out_psel", 64'(sif.out_psel), 64'(0));
        chk("arst.out_mode", 64'(sif.out_mode), 64'(0));
        chk("arst.out_err", 64'(sif.out_err), 64'(0));
        chk("arst.out_side", 64'(sif.out_side), 64'(0));
        chk_pay("arst.payload", sif.out_payload, '0);
        q.delete();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic with stalls and occasional flushes.
        for (int n = 0; n < 600; n++) begin
            if (!sif.in_valid || last_acc) begin
                logic [1:0]    m;
                logic [EW-1:0] a, b, c;
                m = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) begin
                    a = EW'($urandom_range(0, 16383));
                    b = EW'($urandom_range(0, 16383));
                    c = EW'($urandom_range(0, 16383));
                end else begin
                    a = EW'($urandom_range(0, 2047));
                    b = EW'($urandom_range(0, 2047));
                    c = EW'($urandom_range(0, 2047));
                end
                set_beat(m, a, b, c);
            end
            sif.in_valid  = ($urandom_range(0, 3) != 0);
            sif.out_ready = ($urandom_range(0, 2) != 0);
            sif.flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        sif.flush     = 1'b0;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
